// File: rtl/uart_rx16_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver.
package uart_rx16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Tick indices inside one 16-tick bit period
    localparam logic [3:0] SAMPLE_EARLY = 4'd7;
    localparam logic [3:0] SAMPLE_MID   = 4'd8;
    localparam logic [3:0] SAMPLE_LATE  = 4'd9;
    localparam logic [3:0] TICK_LAST    = 4'(OVERSAMPLE - 1);

    // Two-out-of-three vote used for every data and stop bit
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx16_baud_tick.sv
// Oversample tick generator: one-clock pulse every clk_freq/(baud*factor) clocks.
// Shared with the transmitter; clear restarts the period so the receiver can
// align its ticks to a detected start edge.
module uart_baud_tick
    import uart_rx16_pkg::*;
#(
    parameter int clk_freq = 50000000,
    parameter int baud     = 115200,
    parameter int factor   = OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int DIV = clk_freq / (baud * factor);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_bad_div
        $error("uart_baud_tick: clk_freq/(baud*factor) truncates to zero");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Down-counter reloads at terminal count; the tick is the terminal count itself
    always_comb begin
        cnt_d = cnt_q;
        if (clear || cnt_q == '0) begin
            cnt_d = CW'(DIV - 1);
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx16.sv
// UART receiver with 16x oversampling, majority-vote bit decisions,
// a single holding register and sticky framing/overrun flags.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a synchronized low with rx_enable
// ST_START | start bit seen, confirm it at tick 8 (high = glitch)
// ST_DATA  | finish start bit, then vote and shift 8 data bits LSB first
// ST_STOP  | vote stop bit at ticks 7/8/9, deliver byte after tick 15
module uart_rx16
    import uart_rx16_pkg::*;
#(
    parameter int clk_freq = 50000000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_enable,
    input  logic       uld_rx_data,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_frame_err,
    output logic       rx_over,
    output logic       rx_busy
);

    logic       tick;
    logic       tick_clr;
    logic       rx_s;
    logic       done;

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    rx_state_t  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] samp_q, samp_d;
    logic       half_q, half_d;
    logic [7:0] shift_q, shift_d;
    logic       stop_ok_q, stop_ok_d;
    logic [7:0] data_q, data_d;
    logic       empty_q, empty_d;
    logic       ferr_q, ferr_d;
    logic       over_q, over_d;
    logic       busy_q, busy_d;

    uart_baud_tick #(
        .clk_freq (clk_freq),
        .baud     (baud),
        .factor   (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clr),
        .tick  (tick)
    );

    assign rx_s = sync2_q;

    // Next-state logic: synchronizer, receive FSM, holding register and flags
    always_comb begin
        sync1_d    = rx_in;
        sync2_d    = sync1_q;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        half_d     = half_q;
        shift_d    = shift_q;
        stop_ok_d  = stop_ok_q;
        data_d     = data_q;
        empty_d    = empty_q;
        ferr_d     = ferr_q;
        over_d     = over_q;
        busy_d     = busy_q;
        tick_clr   = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_enable && !rx_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    tick_clr   = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == SAMPLE_MID) begin
                        if (rx_s) begin
                            state_d    = ST_IDLE;
                            tick_cnt_d = '0;
                            busy_d     = 1'b0;
                        end else begin
                            // Hand over mid start bit; half_q skips the rest of it
                            state_d   = ST_DATA;
                            half_d    = 1'b1;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (half_q) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            half_d = 1'b0;
                        end
                    end else begin
                        if (tick_cnt_q == SAMPLE_EARLY) samp_d[0] = rx_s;
                        if (tick_cnt_q == SAMPLE_MID)   samp_d[1] = rx_s;
                        if (tick_cnt_q == SAMPLE_LATE) begin
                            shift_d = {majority3(samp_q[0], samp_q[1], rx_s), shift_q[7:1]};
                        end
                        if (tick_cnt_q == TICK_LAST) begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_d = ST_STOP;
                            end
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == SAMPLE_EARLY) samp_d[0] = rx_s;
                    if (tick_cnt_q == SAMPLE_MID)   samp_d[1] = rx_s;
                    if (tick_cnt_q == SAMPLE_LATE) begin
                        stop_ok_d = majority3(samp_q[0], samp_q[1], rx_s);
                    end
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d    = ST_IDLE;
                        tick_cnt_d = '0;
                        busy_d     = 1'b0;
                        done       = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Disabling abandons any partial frame but leaves held data alone
        if (!rx_enable) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            half_d     = 1'b0;
            busy_d     = 1'b0;
            done       = 1'b0;
            tick_clr   = 1'b0;
        end

        // Unload first, so a coincident completion lands in a free register
        if (uld_rx_data) begin
            empty_d = 1'b1;
            over_d  = 1'b0;
            ferr_d  = 1'b0;
        end
        if (done) begin
            if (empty_q || uld_rx_data) begin
                data_d  = shift_q;
                empty_d = 1'b0;
            end else begin
                over_d = 1'b1;
            end
            if (!stop_ok_q) begin
                ferr_d = 1'b1;
            end
        end
    end

    // All state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            half_q     <= 1'b0;
            shift_q    <= '0;
            stop_ok_q  <= 1'b0;
            data_q     <= '0;
            empty_q    <= 1'b1;
            ferr_q     <= 1'b0;
            over_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            half_q     <= half_d;
            shift_q    <= shift_d;
            stop_ok_q  <= stop_ok_d;
            data_q     <= data_d;
            empty_q    <= empty_d;
            ferr_q     <= ferr_d;
            over_q     <= over_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_empty     = empty_q;
    assign rx_frame_err = ferr_q;
    assign rx_over      = over_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx16.sv
// Directed bench for uart_rx16 at 16 clocks per bit, with a frame-level
// reference model compared against the outputs on every clock.
module tb_uart_rx16;

    // Start detection is seen 3 clocks after the line edge (two synchronizer
    // stages plus the FSM register); a frame then spans 10 bits of 16 ticks.
    localparam int DETECT   = 3;
    localparam int LAT      = DETECT + 10 * 16;
    localparam int GLITCH_T = DETECT + 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       rx_enable;
    logic       uld_rx_data;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_frame_err;
    logic       rx_over;
    logic       rx_busy;

    uart_rx16 #(
        .clk_freq (1600000),
        .baud     (100000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .rx_enable    (rx_enable),
        .uld_rx_data  (uld_rx_data),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_frame_err (rx_frame_err),
        .rx_over      (rx_over),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // frame currently on the line, as registered by the stimulus
    int         fr_k;
    logic [7:0] fr_byte;
    bit         fr_stop;
    bit         fr_glitch;
    bit         fr_active = 1'b0;

    // expected outputs
    logic [7:0] m_data  = 8'h00;
    logic       m_empty = 1'b1;
    logic       m_ferr  = 1'b0;
    logic       m_over  = 1'b0;
    logic       m_busy  = 1'b0;

    bit comp;

    // Reference model: applies each clock's inputs to the frame-level rules
    always @(posedge clk) begin
        cyc++;
        comp = 1'b0;
        if (reset) begin
            m_data = 8'h00; m_empty = 1'b1; m_ferr = 1'b0; m_over = 1'b0; m_busy = 1'b0;
            fr_active = 1'b0;
        end else begin
            if (!rx_enable) begin
                m_busy = 1'b0;
                fr_active = 1'b0;
            end else if (fr_active) begin
                if (cyc == fr_k + DETECT) m_busy = 1'b1;
                if (fr_glitch && cyc == fr_k + GLITCH_T) begin
                    m_busy = 1'b0;
                    fr_active = 1'b0;
                end
                if (!fr_glitch && cyc == fr_k + LAT) comp = 1'b1;
            end
            if (uld_rx_data) begin
                m_empty = 1'b1; m_over = 1'b0; m_ferr = 1'b0;
            end
            if (comp) begin
                if (m_empty) begin
                    m_data = fr_byte;
                    m_empty = 1'b0;
                end else begin
                    m_over = 1'b1;
                end
                if (!fr_stop) m_ferr = 1'b1;
                m_busy = 1'b0;
                fr_active = 1'b0;
            end
        end
    end

    // Compare process: every clock once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            n_total += 5;
            if (rx_data === m_data) n_pass++;
            else $display("FAIL model rx_data cyc=%0d got=%h exp=%h", cyc, rx_data, m_data);
            if (rx_empty === m_empty) n_pass++;
            else $display("FAIL model rx_empty cyc=%0d got=%b exp=%b", cyc, rx_empty, m_empty);
            if (rx_frame_err === m_ferr) n_pass++;
            else $display("FAIL model rx_frame_err cyc=%0d got=%b exp=%b", cyc, rx_frame_err, m_ferr);
            if (rx_over === m_over) n_pass++;
            else $display("FAIL model rx_over cyc=%0d got=%b exp=%b", cyc, rx_over, m_over);
            if (rx_busy === m_busy) n_pass++;
            else $display("FAIL model rx_busy cyc=%0d got=%b exp=%b", cyc, rx_busy, m_busy);
        end
    end

    // Observers for a couple of literal checks
    bit busy_seen = 1'b0;
    int fall_cyc  = -1;
    logic prev_empty = 1'b1;
    always @(negedge clk) begin
        if (rx_busy === 1'b1) busy_seen = 1'b1;
        if (prev_empty === 1'b1 && rx_empty === 1'b0) fall_cyc = cyc;
        prev_empty = rx_empty;
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic unload();
        @(posedge clk); #1;
        uld_rx_data = 1'b1;
        @(posedge clk); #1;
        uld_rx_data = 1'b0;
    endtask

    // Drive one 10-bit frame, 16 clocks per bit. drop_at / rst_at give the
    // clock offset at which rx_enable is dropped or reset pulsed (-1 = never).
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int drop_at, input int rst_at);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        @(posedge clk); #1;
        fr_k = cyc; fr_byte = b; fr_stop = stop_ok; fr_glitch = 1'b0; fr_active = 1'b1;
        for (int i = 0; i < 160; i++) begin
            rx_in = bits[i / 16];
            if (i == drop_at) rx_enable = 1'b0;
            reset = (i == rst_at);
            @(posedge clk); #1;
        end
        rx_in = 1'b1;
        reset = 1'b0;
        rx_enable = 1'b1;
    endtask

    initial begin
        int k0;
        reset = 1'b1; rx_in = 1'b1; rx_enable = 1'b1; uld_rx_data = 1'b0;
        idle(3);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_empty", {7'd0, rx_empty}, 8'd1);
        check("reset flags", {6'd0, rx_frame_err, rx_over}, 8'd0);
        check("reset rx_busy", {7'd0, rx_busy}, 8'd0);
        idle(5);

        // 0x55, good stop
        send_frame(8'h55, 1'b1, -1, -1);
        k0 = fr_k;
        idle(20);
        check("0x55 rx_data", rx_data, 8'h55);
        check("0x55 rx_empty", {7'd0, rx_empty}, 8'd0);
        check("0x55 flags", {6'd0, rx_frame_err, rx_over}, 8'd0);
        check("0x55 empty fall near 160", {7'd0, (fall_cyc - k0 >= 155 && fall_cyc - k0 <= 170)}, 8'd1);
        unload();
        idle(5);

        // 4-clock glitch in idle
        busy_seen = 1'b0;
        @(posedge clk); #1;
        fr_k = cyc; fr_glitch = 1'b1; fr_active = 1'b1;
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        idle(30);
        check("glitch busy pulsed", {7'd0, busy_seen}, 8'd1);
        check("glitch rx_empty", {7'd0, rx_empty}, 8'd1);
        check("glitch rx_busy", {7'd0, rx_busy}, 8'd0);

        // 0xA3 with low stop bit
        send_frame(8'hA3, 1'b0, -1, -1);
        idle(20);
        check("0xA3 rx_data", rx_data, 8'hA3);
        check("0xA3 rx_frame_err", {7'd0, rx_frame_err}, 8'd1);
        unload();
        idle(2);
        check("unload clears frame_err", {7'd0, rx_frame_err}, 8'd0);
        check("unload sets rx_empty", {7'd0, rx_empty}, 8'd1);

        // overrun: 0x11 then 0x22 without unloading
        send_frame(8'h11, 1'b1, -1, -1);
        idle(20);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(20);
        check("overrun rx_data", rx_data, 8'h11);
        check("overrun rx_over", {7'd0, rx_over}, 8'd1);
        unload();
        idle(5);

        // same pair, unload on the completion clock of the second byte
        send_frame(8'h11, 1'b1, -1, -1);
        idle(20);
        send_frame(8'h22, 1'b1, -1, -1);
        repeat (LAT - 161) @(posedge clk);
        #1;
        uld_rx_data = 1'b1;
        @(posedge clk); #1;
        uld_rx_data = 1'b0;
        idle(10);
        check("coincident rx_data", rx_data, 8'h22);
        check("coincident rx_over", {7'd0, rx_over}, 8'd0);
        check("coincident rx_empty", {7'd0, rx_empty}, 8'd0);
        unload();
        idle(5);

        // enable dropped in the middle of data bit 4 of 0xF0
        send_frame(8'hF0, 1'b1, 5 * 16 + 8, -1);
        idle(20);
        check("abort rx_empty", {7'd0, rx_empty}, 8'd1);
        check("abort rx_busy", {7'd0, rx_busy}, 8'd0);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(20);
        check("after abort rx_data", rx_data, 8'h3C);
        check("after abort rx_empty", {7'd0, rx_empty}, 8'd0);

        // reset pulsed during data bit 2 of 0xFC while 0x3C is held
        send_frame(8'hFC, 1'b1, -1, 3 * 16 + 8);
        idle(20);
        check("reset mid-frame rx_data", rx_data, 8'h00);
        check("reset mid-frame rx_empty", {7'd0, rx_empty}, 8'd1);
        check("reset mid-frame rx_busy", {7'd0, rx_busy}, 8'd0);
        check("reset mid-frame flags", {6'd0, rx_frame_err, rx_over}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
